// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM status codes and arbiter FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side fetch/data requests and the single RAM port behind the arbiter.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // instruction fetch path
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  // data path
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  // RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win, but instruction fetch is forced
// after MAX_DSTREAK consecutive data completions while a fetch is pending.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  arb_state_t          state;
  logic [STREAK_W-1:0] dstreak;
  logic                d_req;
  logic                d_done;
  logic                i_done;
  logic                force_i;

  always_comb begin
    d_req   = bus.dREN | bus.dWEN;
    d_done  = (state == GNT_D) && d_req && (bus.ramstate == ACCESS);
    i_done  = (state == GNT_I) && bus.iREN && (bus.ramstate == ACCESS);
    force_i = bus.iREN && (dstreak == STREAK_MAX);
  end

  // State register with arbitration and saturating starvation counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req && !force_i)  state <= GNT_D;
          else if (bus.iREN)      state <= GNT_I;
          else                    state <= IDLE;
        end
        GNT_D: begin
          // abort and completion both return to IDLE; ERROR keeps retrying
          if (!d_req || d_done)   state <= IDLE;
        end
        GNT_I: begin
          if (!bus.iREN || i_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!bus.iREN || i_done)
        dstreak <= '0;
      else if (d_done && (dstreak != STREAK_MAX))
        dstreak <= dstreak + STREAK_W'(1);
    end
  end

  // Combinational RAM drive and wait/load returns from state plus inputs.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = DATA_W'(bus.ramload);
    bus.dload    = DATA_W'(bus.ramload);
    case (state)
      GNT_D: begin
        bus.ramaddr  = ADDR_W'(bus.daddr);
        bus.ramstore = DATA_W'(bus.dstore);
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.dwait    = !d_done;
      end
      GNT_I: begin
        bus.ramaddr  = ADDR_W'(bus.iaddr);
        bus.ramREN   = bus.iREN;
        bus.iwait    = !i_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic CLK = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One arbitration round with both requesters active: IDLE gap then a one-cycle ACCESS grant.
  task automatic round(input bit exp_d, input string tag);
    bus.ramstate = FREE;
    #1;
    check({tag, "_gap_en"}, 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    tick();
    bus.ramstate = ACCESS;
    #1;
    check({tag, "_dwait"}, 64'(bus.dwait), 64'(!exp_d));
    check({tag, "_iwait"}, 64'(bus.iwait), 64'(exp_d));
    tick();
  endtask

  initial begin
    bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset with requests pending
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = '0;
    bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'hDEADBEEF; bus.ramstate = FREE;
    tick(); tick();
    check("rst_ren",   64'(bus.ramREN), 64'd0);
    check("rst_wen",   64'(bus.ramWEN), 64'd0);
    check("rst_iwait", 64'(bus.iwait),  64'd1);
    check("rst_dwait", 64'(bus.dwait),  64'd1);
    check("rst_addr",  64'(bus.ramaddr), 64'd0);
    check("rst_iload", 64'(bus.iload),  64'hDEADBEEF);
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    nRST = 1'b1;
    tick();

    // lone fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    #1;
    check("f_idle_ren", 64'(bus.ramREN), 64'd0);
    tick();
    bus.ramstate = BUSY;
    #1;
    check("f_gnt_ren",  64'(bus.ramREN),  64'd1);
    check("f_gnt_addr", 64'(bus.ramaddr), 64'h40);
    check("f_gnt_wait", 64'(bus.iwait),   64'd1);
    tick();
    bus.ramstate = ACCESS;
    #1;
    check("f_acc_iwait", 64'(bus.iwait), 64'd0);
    check("f_acc_iload", 64'(bus.iload), 64'hDEADBEEF);
    check("f_acc_dwait", 64'(bus.dwait), 64'd1);
    tick();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    check("f_after_ren",  64'(bus.ramREN), 64'd0);
    check("f_after_wait", 64'(bus.iwait),  64'd1);
    tick();

    // contention: write beats fetch, fetch follows after one IDLE cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    #1;
    check("c_idle_en", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    tick();
    bus.ramstate = ACCESS;
    #1;
    check("c_d_wen",   64'(bus.ramWEN),   64'd1);
    check("c_d_ren",   64'(bus.ramREN),   64'd0);
    check("c_d_addr",  64'(bus.ramaddr),  64'h80);
    check("c_d_store", 64'(bus.ramstore), 64'h1234);
    check("c_d_dwait", 64'(bus.dwait),    64'd0);
    check("c_d_iwait", 64'(bus.iwait),    64'd1);
    tick();
    bus.dWEN = 1'b0; bus.ramstate = FREE;
    #1;
    check("c_gap_en", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
    tick();
    bus.ramstate = ACCESS;
    #1;
    check("c_i_ren",   64'(bus.ramREN),   64'd1);
    check("c_i_addr",  64'(bus.ramaddr),  64'h44);
    check("c_i_store", 64'(bus.ramstore), 64'd0);
    check("c_i_iwait", 64'(bus.iwait),    64'd0);
    check("c_i_dwait", 64'(bus.dwait),    64'd1);
    tick();

    // starvation: fetch held, data re-requested back to back
    bus.dREN = 1'b1; bus.daddr = 32'h90;
    for (int k = 0; k < 6; k++) round(exp_seq[k], $sformatf("starve%0d", k));

    // BUSY, BUSY, ERROR then ACCESS on a data read
    bus.iREN = 1'b0; bus.daddr = 32'h100; bus.ramload = 32'hCAFEF00D;
    bus.ramstate = FREE;
    tick();
    begin
      ramstate_t seq [4] = '{BUSY, BUSY, ERROR, ACCESS};
      for (int k = 0; k < 4; k++) begin
        bus.ramstate = seq[k];
        #1;
        check($sformatf("be%0d_ren", k),   64'(bus.ramREN),  64'd1);
        check($sformatf("be%0d_addr", k),  64'(bus.ramaddr), 64'h100);
        check($sformatf("be%0d_dwait", k), 64'(bus.dwait),   64'(k != 3));
        tick();
      end
    end
    check("be_dload", 64'(bus.dload), 64'hCAFEF00D);
    bus.ramstate = FREE;

    // abort: drop data read mid-access while BUSY
    tick();
    bus.ramstate = BUSY;
    #1;
    check("ab_gnt_ren", 64'(bus.ramREN), 64'd1);
    tick();
    bus.dREN = 1'b0;
    #1;
    check("ab_drop_ren",   64'(bus.ramREN), 64'd0);
    check("ab_drop_dwait", 64'(bus.dwait),  64'd1);
    tick();
    bus.ramstate = ACCESS;
    #1;
    check("ab_idle_ren",   64'(bus.ramREN), 64'd0);
    check("ab_idle_dwait", 64'(bus.dwait),  64'd1);
    bus.ramstate = FREE;
    tick();

    // build streak to the limit, then reset during the forced fetch
    bus.iREN = 1'b1; bus.dREN = 1'b1;
    for (int k = 0; k < 4; k++) round(1'b1, $sformatf("pre%0d", k));
    bus.ramstate = FREE;
    tick();
    bus.ramstate = BUSY;
    #1;
    check("rs_gnt_i_ren",  64'(bus.ramREN),  64'd1);
    check("rs_gnt_i_addr", 64'(bus.ramaddr), 64'h44);
    check("rs_gnt_dwait",  64'(bus.dwait),   64'd1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.ramstate = ACCESS;
    #1;
    check("rs_idle_ren",   64'(bus.ramREN), 64'd0);
    check("rs_idle_iwait", 64'(bus.iwait),  64'd1);
    tick();
    #1;
    check("rs_clr_dwait", 64'(bus.dwait), 64'd0);
    check("rs_clr_iwait", 64'(bus.iwait), 64'd1);
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
